instruction_fetch_unit: RTL and testbench

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

---
 rtl/instruction_fetch_unit.sv | 80 ++++++++
 tb/tb_instruction_fetch_unit.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: a two-state FETCH/DELIVER machine that issues one
// memory read at a time and delivers each fetched word, tracking redirects.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [31:0] RedirectAddress,
    output logic        MemReq,
    output logic [31:0] MemAddr,
    input  logic        MemAck,
    input  logic [31:0] MemData,
    output logic        InstrValid,
    output logic [31:0] Instruction,
    output logic [31:0] Instr_PC_Plus4
);

    typedef enum logic {
        FETCH   = 1'b0,
        DELIVER = 1'b1
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_pend_valid;
    logic [31:0] r_pend_addr;
    logic [31:0] r_instr;
    logic [31:0] r_pc_plus4;
    logic [31:0] w_pc_plus4;

    assign w_pc_plus4     = r_pc + 32'd4;
    assign MemAddr        = r_pc;
    // Reset parks the machine in FETCH; gating keeps the request low until release.
    assign MemReq         = (r_state == FETCH) && !RESET;
    assign InstrValid     = (r_state == DELIVER);
    assign Instruction    = r_instr;
    assign Instr_PC_Plus4 = r_pc_plus4;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state      <= FETCH;
            r_pc         <= RESET_PC;
            r_pend_valid <= 1'b0;
            r_pend_addr  <= '0;
            r_instr      <= '0;
            r_pc_plus4   <= '0;
        end else begin
            case (r_state)
                FETCH: begin
                    if (MemAck) begin
                        r_instr      <= MemData;
                        r_pc_plus4   <= w_pc_plus4;
                        r_pend_valid <= 1'b0;
                        r_state      <= DELIVER;
                        if (Redirect)
                            r_pc <= RedirectAddress;
                        else if (r_pend_valid)
                            r_pc <= r_pend_addr;
                        else
                            r_pc <= w_pc_plus4;
                    end else if (Redirect) begin
                        // The request in flight must stay put, so park the target.
                        r_pend_addr  <= RedirectAddress;
                        r_pend_valid <= 1'b1;
                    end
                end
                DELIVER: begin
                    if (Redirect)
                        r_pc <= RedirectAddress;
                    if (!Stall)
                        r_state <= FETCH;
                end
                default: r_state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: scenario tasks driving a
// cycle-accurate stimulus with a scoreboard of expected deliveries.
module tb_instruction_fetch_unit;

    localparam logic [31:0] RST_PC = 32'hBFC00000;

    logic        CLK;
    logic        RESET;
    logic        Stall;
    logic        Redirect;
    logic [31:0] RedirectAddress;
    logic        MemReq;
    logic [31:0] MemAddr;
    logic        MemAck;
    logic [31:0] MemData;
    logic        InstrValid;
    logic [31:0] Instruction;
    logic [31:0] Instr_PC_Plus4;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;

    exp_t sb[$];
    int   tests_run;
    int   tests_failed;

    instruction_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .Stall          (Stall),
        .Redirect       (Redirect),
        .RedirectAddress(RedirectAddress),
        .MemReq         (MemReq),
        .MemAddr        (MemAddr),
        .MemAck         (MemAck),
        .MemData        (MemData),
        .InstrValid     (InstrValid),
        .Instruction    (Instruction),
        .Instr_PC_Plus4 (Instr_PC_Plus4)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // Drive one cycle of inputs, then land 1 time unit after the next rising edge.
    task automatic cyc(input logic st, input logic rd, input logic [31:0] ra,
                       input logic ack, input logic [31:0] data);
        Stall           = st;
        Redirect        = rd;
        RedirectAddress = ra;
        MemAck          = ack;
        MemData         = data;
        @(posedge CLK);
        #1;
    endtask

    // From FETCH: complete the current fetch with a redirect and return to FETCH at addr.
    task automatic goto_fetch(input logic [31:0] addr);
        cyc(1'b0, 1'b1, addr, 1'b1, 32'h0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic test_reset;
        RESET = 1'b1;
        cyc(1'b0, 1'b1, 32'h1234_5678, 1'b1, 32'hCAFE_F00D);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'hCAFE_F00D);
        tests_run++;
        if (MemReq !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_memreq: got %b expected 0", MemReq);
        end
        tests_run++;
        if (InstrValid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_valid: got %b expected 0", InstrValid);
        end
        tests_run++;
        if (Instruction !== 32'h0 || Instr_PC_Plus4 !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h/%h expected 0/0", Instruction, Instr_PC_Plus4);
        end
        MemAck = 1'b0;
        Redirect = 1'b0;
        RESET = 1'b0;
        #1;
        tests_run++;
        if (MemReq !== 1'b1 || MemAddr !== RST_PC) begin
            tests_failed++;
            $display("FAIL reset_release: got req=%b addr=%h expected 1/%h", MemReq, MemAddr, RST_PC);
        end
    endtask

    task automatic test_sequential;
        logic [31:0] ea;
        exp_t e;
        ea = RST_PC;
        for (int unsigned k = 0; k < 3; k++) begin
            tests_run++;
            if (MemReq !== 1'b1 || InstrValid !== 1'b0 || MemAddr !== ea) begin
                tests_failed++;
                $display("FAIL seq_fetch%0d: got req=%b vld=%b addr=%h expected 1/0/%h",
                         k, MemReq, InstrValid, MemAddr, ea);
            end
            sb.push_back('{instr: ea, pc4: ea + 32'd4});
            cyc(1'b0, 1'b0, 32'h0, 1'b1, ea);
            tests_run++;
            if (InstrValid !== 1'b1 || MemReq !== 1'b0 || sb.size() == 0) begin
                tests_failed++;
                $display("FAIL seq_deliver%0d: got vld=%b req=%b expected 1/0", k, InstrValid, MemReq);
            end else begin
                e = sb.pop_front();
                if (Instruction !== e.instr || Instr_PC_Plus4 !== e.pc4) begin
                    tests_failed++;
                    $display("FAIL seq_data%0d: got %h/%h expected %h/%h",
                             k, Instruction, Instr_PC_Plus4, e.instr, e.pc4);
                end
            end
            cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
            ea = ea + 32'd4;
        end
    endtask

    task automatic test_fetch_wait_redirect;
        exp_t e;
        goto_fetch(32'h100);
        for (int unsigned k = 0; k < 3; k++) begin
            tests_run++;
            if (MemReq !== 1'b1 || MemAddr !== 32'h100) begin
                tests_failed++;
                $display("FAIL wait_stable%0d: got req=%b addr=%h expected 1/00000100", k, MemReq, MemAddr);
            end
            cyc(1'b0, (k == 1), 32'h400, 1'b0, 32'h0);
        end
        sb.push_back('{instr: 32'hA000_0100, pc4: 32'h104});
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'hA000_0100);
        tests_run++;
        if (InstrValid !== 1'b1 || sb.size() == 0) begin
            tests_failed++;
            $display("FAIL wait_deliver: got vld=%b expected 1", InstrValid);
        end else begin
            e = sb.pop_front();
            if (Instruction !== e.instr || Instr_PC_Plus4 !== e.pc4) begin
                tests_failed++;
                $display("FAIL wait_data: got %h/%h expected %h/%h", Instruction, Instr_PC_Plus4, e.instr, e.pc4);
            end
        end
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        tests_run++;
        if (MemReq !== 1'b1 || MemAddr !== 32'h400) begin
            tests_failed++;
            $display("FAIL wait_next: got req=%b addr=%h expected 1/00000400", MemReq, MemAddr);
        end
    endtask

    task automatic test_stall_redirect;
        exp_t e;
        sb.push_back('{instr: 32'hB000_0400, pc4: 32'h404});
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'hB000_0400);
        e = '0;
        if (sb.size() != 0) e = sb.pop_front();
        for (int unsigned k = 0; k < 5; k++) begin
            tests_run++;
            if (InstrValid !== 1'b1 || MemReq !== 1'b0 ||
                Instruction !== e.instr || Instr_PC_Plus4 !== e.pc4) begin
                tests_failed++;
                $display("FAIL stall_hold%0d: got vld=%b req=%b %h/%h expected 1/0 %h/%h",
                         k, InstrValid, MemReq, Instruction, Instr_PC_Plus4, e.instr, e.pc4);
            end
            cyc((k < 4), (k == 1), 32'h800, 1'b0, 32'h0);
        end
        tests_run++;
        if (MemReq !== 1'b1 || InstrValid !== 1'b0 || MemAddr !== 32'h800) begin
            tests_failed++;
            $display("FAIL stall_next: got req=%b vld=%b addr=%h expected 1/0/00000800",
                     MemReq, InstrValid, MemAddr);
        end
    endtask

    task automatic test_pending_priority;
        cyc(1'b0, 1'b1, 32'h300, 1'b0, 32'h0);
        cyc(1'b0, 1'b1, 32'h200, 1'b1, 32'h0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        tests_run++;
        if (MemAddr !== 32'h200) begin
            tests_failed++;
            $display("FAIL prio_redirect: got addr=%h expected 00000200", MemAddr);
        end
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        tests_run++;
        if (MemAddr !== 32'h204) begin
            tests_failed++;
            $display("FAIL prio_pend_cleared: got addr=%h expected 00000204", MemAddr);
        end
        cyc(1'b0, 1'b1, 32'h500, 1'b0, 32'h0);
        cyc(1'b0, 1'b1, 32'h604, 1'b0, 32'h0);
        tests_run++;
        if (MemAddr !== 32'h204) begin
            tests_failed++;
            $display("FAIL pend_hold_addr: got addr=%h expected 00000204", MemAddr);
        end
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        tests_run++;
        if (MemAddr !== 32'h604) begin
            tests_failed++;
            $display("FAIL pend_overwrite: got addr=%h expected 00000604", MemAddr);
        end
    endtask

    task automatic test_unaligned;
        exp_t e;
        goto_fetch(32'h123);
        tests_run++;
        if (MemAddr !== 32'h123) begin
            tests_failed++;
            $display("FAIL unaligned_addr: got %h expected 00000123", MemAddr);
        end
        sb.push_back('{instr: 32'h0C0F_FEE0, pc4: 32'h127});
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h0C0F_FEE0);
        tests_run++;
        if (sb.size() == 0) begin
            tests_failed++;
            $display("FAIL unaligned_sb: got empty scoreboard expected one entry");
        end else begin
            e = sb.pop_front();
            if (InstrValid !== 1'b1 || Instruction !== e.instr || Instr_PC_Plus4 !== e.pc4) begin
                tests_failed++;
                $display("FAIL unaligned_data: got %b %h/%h expected 1 %h/%h",
                         InstrValid, Instruction, Instr_PC_Plus4, e.instr, e.pc4);
            end
        end
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic test_wrap;
        exp_t e;
        goto_fetch(32'hFFFF_FFFC);
        sb.push_back('{instr: 32'h5555_AAAA, pc4: 32'h0});
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h5555_AAAA);
        tests_run++;
        if (sb.size() == 0) begin
            tests_failed++;
            $display("FAIL wrap_sb: got empty scoreboard expected one entry");
        end else begin
            e = sb.pop_front();
            if (InstrValid !== 1'b1 || Instruction !== e.instr || Instr_PC_Plus4 !== e.pc4) begin
                tests_failed++;
                $display("FAIL wrap_data: got %b %h/%h expected 1 %h/%h",
                         InstrValid, Instruction, Instr_PC_Plus4, e.instr, e.pc4);
            end
        end
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        tests_run++;
        if (MemReq !== 1'b1 || MemAddr !== 32'h0) begin
            tests_failed++;
            $display("FAIL wrap_next: got req=%b addr=%h expected 1/00000000", MemReq, MemAddr);
        end
    endtask

    task automatic test_reset_mid_fetch;
        exp_t e;
        MemAck  = 1'b1;
        MemData = 32'hDEAD_BEEF;
        #2;
        RESET = 1'b1;
        #1;
        tests_run++;
        if (MemReq !== 1'b0 || InstrValid !== 1'b0 || MemAddr !== RST_PC) begin
            tests_failed++;
            $display("FAIL async_reset: got req=%b vld=%b addr=%h expected 0/0/%h",
                     MemReq, InstrValid, MemAddr, RST_PC);
        end
        @(posedge CLK);
        #1;
        tests_run++;
        if (Instruction !== 32'h0 || InstrValid !== 1'b0 || MemReq !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ack_ignored: got %h vld=%b req=%b expected 0/0/0",
                     Instruction, InstrValid, MemReq);
        end
        MemAck = 1'b0;
        RESET  = 1'b0;
        #1;
        tests_run++;
        if (MemReq !== 1'b1 || MemAddr !== RST_PC) begin
            tests_failed++;
            $display("FAIL reset_rerelease: got req=%b addr=%h expected 1/%h", MemReq, MemAddr, RST_PC);
        end
        sb.push_back('{instr: 32'h1111_2222, pc4: RST_PC + 32'd4});
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h1111_2222);
        tests_run++;
        if (sb.size() == 0) begin
            tests_failed++;
            $display("FAIL post_reset_sb: got empty scoreboard expected one entry");
        end else begin
            e = sb.pop_front();
            if (InstrValid !== 1'b1 || Instruction !== e.instr || Instr_PC_Plus4 !== e.pc4) begin
                tests_failed++;
                $display("FAIL post_reset_data: got %b %h/%h expected 1 %h/%h",
                         InstrValid, Instruction, Instr_PC_Plus4, e.instr, e.pc4);
            end
        end
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("FAIL sb_drained: got %0d entries expected 0", sb.size());
        end
    endtask

    initial begin
        tests_run       = 0;
        tests_failed    = 0;
        RESET           = 1'b1;
        Stall           = 1'b0;
        Redirect        = 1'b0;
        RedirectAddress = 32'h0;
        MemAck          = 1'b0;
        MemData         = 32'h0;
        test_reset;
        test_sequential;
        test_fetch_wait_redirect;
        test_stall_redirect;
        test_pending_priority;
        test_unaligned;
        test_wrap;
        test_reset_mid_fetch;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
